// File: rtl/risc_v_core_pkg.sv
// Shared types and defaults for the core's memory-side blocks.
package risc_v_core_pkg;

  // Memory port arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_e;

  // Which core port owns the shared memory bus.
  typedef enum logic {
    OWN_IF,
    OWN_LSU
  } arb_owner_e;

  // Default stall budget before a bus transaction is forced to an error.
  localparam int MEM_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog for the memory port arbiter: counts cycles while enabled and
// flags expiry once the count reaches TIMEOUT_CYC. TIMEOUT_CYC=0 disables it.
module mem_arb_watchdog
  import risc_v_core_pkg::*;
#(
  parameter int TIMEOUT_CYC = MEM_TIMEOUT_CYC
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count_q;

  // Cycle counter: cleared on a new transaction, saturates at the limit.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_in) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && enable && (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto the single shared
// memory bus. One outstanding transaction, round-robin on ties, LSU bus lock
// for atomic sequences, and a watchdog that turns a stalled access into an
// error response.
module mem_port_arbiter
  import risc_v_core_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = MEM_TIMEOUT_CYC
) (
  input  logic                clk_in,
  input  logic                rst_in,
  // Instruction-fetch port
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  // Load/store port
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic                lsu_lock_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_err_o,
  // Shared memory bus
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_err_i
);

  arb_state_e  state_q;
  arb_owner_e  owner_q;
  arb_owner_e  last_owner_q;
  logic        lock_q;

  logic        if_win;
  logic        lsu_win;
  logic        wd_enable;
  logic        wd_expire;
  logic        resp_bus;
  logic        resp_timeout;
  logic        resp_valid;
  logic        resp_err;
  logic [DATA_W-1:0] resp_rdata;

  // Pick the winner among current requesters while the bus is idle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    if_win  = 1'b0;
    lsu_win = 1'b0;
    if (!rst_in && (state_q == ARB_IDLE)) begin
      if (lock_q) begin
        lsu_win = lsu_req_i;
      end else if (if_req_i && lsu_req_i) begin
        if (last_owner_q == OWN_IF) lsu_win = 1'b1;
        else                        if_win  = 1'b1;
      end else begin
        if_win  = if_req_i;
        lsu_win = lsu_req_i;
      end
    end
  end

  assign if_gnt_o  = if_win;
  assign lsu_gnt_o = lsu_win;

  // A real bus response wins over a timeout landing in the same cycle.
  assign resp_bus = !rst_in && mem_rvalid_i &&
                    ((state_q == ARB_WAIT) || ((state_q == ARB_REQ) && mem_gnt_i));
  assign resp_timeout = !rst_in && !resp_bus && wd_expire;
  assign resp_valid   = resp_bus || resp_timeout;
  assign resp_err     = resp_timeout || mem_err_i;
  assign resp_rdata   = resp_timeout ? '0 : mem_rdata_i;

  // Route the response to the owning port; idle ports see zero data.
  assign if_rvalid_o  = resp_valid && (owner_q == OWN_IF);
  assign if_err_o     = if_rvalid_o && resp_err;
  assign if_rdata_o   = if_rvalid_o ? resp_rdata : '0;
  assign lsu_rvalid_o = resp_valid && (owner_q == OWN_LSU);
  assign lsu_err_o    = lsu_rvalid_o && resp_err;
  assign lsu_rdata_o  = lsu_rvalid_o ? resp_rdata : '0;

  assign wd_enable = (state_q == ARB_REQ) || (state_q == ARB_WAIT);

  mem_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (if_win || lsu_win),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // Transaction FSM with registered bus outputs, owner and lock tracking.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      lock_q       <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_be_o     <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (if_win) begin
            mem_req_o    <= 1'b1;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '1;
            mem_addr_o   <= if_addr_i;
            mem_wdata_o  <= '0;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            state_q      <= ARB_REQ;
          end else if (lsu_win) begin
            mem_req_o    <= 1'b1;
            mem_we_o     <= lsu_we_i;
            mem_be_o     <= lsu_be_i;
            mem_addr_o   <= lsu_addr_i;
            mem_wdata_o  <= lsu_wdata_i;
            owner_q      <= OWN_LSU;
            last_owner_q <= OWN_LSU;
            lock_q       <= lsu_lock_i;
            state_q      <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (resp_valid) begin
            mem_req_o <= 1'b0;
            state_q   <= ARB_IDLE;
          end else if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (resp_valid) begin
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state_q   <= ARB_IDLE;
        end
      endcase

      // Any LSU error ends an atomic sequence and releases the bus.
      if (lsu_rvalid_o && resp_err) begin
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch read, round-robin ties, locked
// atomic sequence, bus error, watchdog timeout and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i, lsu_we_i, lsu_lock_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .if_err_o     (if_err_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_lock_i   (lsu_lock_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .lsu_err_o    (lsu_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  always #5 clk_in = ~clk_in;

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One arbitration round with both ports requesting: grant in IDLE, then
  // gnt and rvalid together in REQ so the bus is idle again next cycle.
  task automatic tie_round(input bit exp_lsu, input logic [31:0] rdata);
    #1;
    check("tie_if_gnt",  {31'b0, if_gnt_o},  {31'b0, !exp_lsu});
    check("tie_lsu_gnt", {31'b0, lsu_gnt_o}, {31'b0, exp_lsu});
    tick();
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    #1;
    check("tie_addr",       mem_addr_o, exp_lsu ? 32'h300 : 32'h200);
    check("tie_if_rvalid",  {31'b0, if_rvalid_o},  {31'b0, !exp_lsu});
    check("tie_lsu_rvalid", {31'b0, lsu_rvalid_o}, {31'b0, exp_lsu});
    check("tie_rdata", exp_lsu ? lsu_rdata_o : if_rdata_o, rdata);
    check("tie_other_rdata", exp_lsu ? if_rdata_o : lsu_rdata_o, 32'h0);
    tick();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    if_req_i = 1'b1;  if_addr_i = 32'h200;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h300;
    lsu_wdata_i = 32'h0; lsu_lock_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; mem_err_i = 1'b0;

    // Reset state, with both requests already high.
    tick();
    tick();
    check("rst_if_gnt",  {31'b0, if_gnt_o},  32'h0);
    check("rst_lsu_gnt", {31'b0, lsu_gnt_o}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_be",  {28'b0, mem_be_o},  32'h0);

    // Tie from reset release: LSU, IF, LSU, IF, LSU.
    rst_in = 1'b0;
    tie_round(1'b1, 32'h11);
    tie_round(1'b0, 32'h22);
    tie_round(1'b1, 32'h33);
    tie_round(1'b0, 32'h44);
    tie_round(1'b1, 32'h55);
    if_req_i  = 1'b0;
    lsu_req_i = 1'b0;

    // IF-only read at 0x100.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    #1;
    check("ifrd_if_gnt",  {31'b0, if_gnt_o},  32'h1);
    check("ifrd_lsu_gnt", {31'b0, lsu_gnt_o}, 32'h0);
    tick();
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    check("ifrd_mem_req",  {31'b0, mem_req_o}, 32'h1);
    check("ifrd_mem_addr", mem_addr_o, 32'h100);
    check("ifrd_mem_we",   {31'b0, mem_we_o},  32'h0);
    check("ifrd_mem_be",   {28'b0, mem_be_o},  32'hF);
    check("ifrd_early_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    tick();
    mem_gnt_i = 1'b0;
    #1;
    check("ifrd_req_drop", {31'b0, mem_req_o}, 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13;
    #1;
    check("ifrd_rvalid",     {31'b0, if_rvalid_o},  32'h1);
    check("ifrd_rdata",      if_rdata_o, 32'h13);
    check("ifrd_err",        {31'b0, if_err_o},     32'h0);
    check("ifrd_lsu_rvalid", {31'b0, lsu_rvalid_o}, 32'h0);
    check("ifrd_lsu_rdata",  lsu_rdata_o, 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check("ifrd_idle_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    check("ifrd_idle_rdata",  if_rdata_o, 32'h0);

    // Locked AMO: LSU read with lock while IF keeps requesting.
    if_req_i = 1'b1; if_addr_i = 32'h104;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0000; lsu_lock_i = 1'b1;
    #1;
    check("amo_rd_lsu_gnt", {31'b0, lsu_gnt_o}, 32'h1);
    check("amo_rd_if_gnt",  {31'b0, if_gnt_o},  32'h0);
    tick();
    lsu_req_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    check("amo_rd_addr", mem_addr_o, 32'h8000_0000);
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7;
    #1;
    check("amo_rd_rvalid", {31'b0, lsu_rvalid_o}, 32'h1);
    check("amo_rd_rdata",  lsu_rdata_o, 32'h7);
    check("amo_rd_if_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check("amo_locked_if_gnt", {31'b0, if_gnt_o}, 32'h0);
    tick();
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_wdata_i = 32'h5; lsu_lock_i = 1'b0;
    #1;
    check("amo_wr_lsu_gnt", {31'b0, lsu_gnt_o}, 32'h1);
    check("amo_wr_if_gnt",  {31'b0, if_gnt_o},  32'h0);
    tick();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    check("amo_wr_wdata", mem_wdata_o, 32'h5);
    check("amo_wr_we",    {31'b0, mem_we_o}, 32'h1);
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    #1;
    check("amo_wr_rvalid", {31'b0, lsu_rvalid_o}, 32'h1);
    check("amo_wr_if_gnt_resp", {31'b0, if_gnt_o}, 32'h0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check("amo_if_gnt_after", {31'b0, if_gnt_o}, 32'h1);
    tick();
    if_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    #1;
    check("amo_if_addr",   mem_addr_o, 32'h104);
    check("amo_if_rvalid", {31'b0, if_rvalid_o}, 32'h1);
    check("amo_if_rdata",  if_rdata_o, 32'h99);
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;

    // Bus error on a locked LSU store releases the lock.
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_wdata_i = 32'hAB;
    lsu_addr_i = 32'h10; lsu_lock_i = 1'b1;
    #1;
    check("err_lsu_gnt", {31'b0, lsu_gnt_o}, 32'h1);
    tick();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_lock_i = 1'b0; mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h0;
    #1;
    check("err_lsu_rvalid", {31'b0, lsu_rvalid_o}, 32'h1);
    check("err_lsu_err",    {31'b0, lsu_err_o},    32'h1);
    check("err_lsu_rdata",  lsu_rdata_o, 32'h0);
    check("err_if_rvalid",  {31'b0, if_rvalid_o},  32'h0);
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    #1;
    check("err_unlock_if_gnt", {31'b0, if_gnt_o}, 32'h1);

    // Watchdog: the IF transaction above never sees mem_gnt_i.
    tick();
    if_req_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("to_wait_rvalid",  {31'b0, if_rvalid_o}, 32'h0);
      check("to_wait_mem_req", {31'b0, mem_req_o},   32'h1);
      tick();
    end
    #1;
    check("to_rvalid",     {31'b0, if_rvalid_o},  32'h1);
    check("to_err",        {31'b0, if_err_o},     32'h1);
    check("to_rdata",      if_rdata_o, 32'h0);
    check("to_lsu_rvalid", {31'b0, lsu_rvalid_o}, 32'h0);
    tick();
    #1;
    check("to_req_drop",    {31'b0, mem_req_o},   32'h0);
    check("to_after_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    tick();
    tick();
    mem_rvalid_i = 1'b1;
    #1;
    check("to_stray_if_rvalid",  {31'b0, if_rvalid_o},  32'h0);
    check("to_stray_lsu_rvalid", {31'b0, lsu_rvalid_o}, 32'h0);
    check("to_stray_if_rdata",   if_rdata_o, 32'h0);
    check("to_stray_mem_req",    {31'b0, mem_req_o},    32'h0);
    tick();
    mem_rvalid_i = 1'b0;

    // Reset while waiting for an LSU write response.
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'h3;
    lsu_addr_i = 32'h600; lsu_wdata_i = 32'hAA; lsu_lock_i = 1'b0;
    #1;
    check("rm_lsu_gnt", {31'b0, lsu_gnt_o}, 32'h1);
    tick();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; mem_gnt_i = 1'b1;
    #1;
    check("rm_mem_be", {28'b0, mem_be_o}, 32'h3);
    tick();
    mem_gnt_i = 1'b0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    #1;
    check("rm_mem_req",     {31'b0, mem_req_o},    32'h0);
    check("rm_mem_we",      {31'b0, mem_we_o},     32'h0);
    check("rm_mem_be_clr",  {28'b0, mem_be_o},     32'h0);
    check("rm_mem_addr",    mem_addr_o,  32'h0);
    check("rm_mem_wdata",   mem_wdata_o, 32'h0);
    check("rm_lsu_rvalid",  {31'b0, lsu_rvalid_o}, 32'h0);
    check("rm_lsu_rdata",   lsu_rdata_o, 32'h0);
    check("rm_if_rvalid",   {31'b0, if_rvalid_o},  32'h0);
    check("rm_if_rdata",    if_rdata_o,  32'h0);
    check("rm_lsu_err",     {31'b0, lsu_err_o},    32'h0);
    tick();
    mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h400;
    #1;
    check("rm_next_if_gnt", {31'b0, if_gnt_o}, 32'h1);
    tick();
    if_req_i = 1'b0;
    #1;
    check("rm_next_req",  {31'b0, mem_req_o}, 32'h1);
    check("rm_next_addr", mem_addr_o, 32'h400);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h66;
    #1;
    check("rm_next_rvalid", {31'b0, if_rvalid_o}, 32'h1);
    check("rm_next_rdata",  if_rdata_o, 32'h66);
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
